// File: rtl/z_csa_pkg.sv
// -----------------------------------------------------------------------------
// z_csa_pkg
// Shared definitions for the sequential carry-select adder block:
//   - default operand width and chunk width
//   - controller state encoding (IDLE / RUN / DONE)
//   - helper for sizing the chunk index register
// -----------------------------------------------------------------------------
package z_csa_pkg;

   localparam int Z_CSA_WIDTH_DEF = 32;
   localparam int Z_CSA_CHUNK_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } z_csa_state_e;

   // Width of a counter able to index n chunks (at least one bit).
   function automatic int z_csa_idx_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/z_csa_chunk.sv
// -----------------------------------------------------------------------------
// z_csa_chunk
// Purely combinational CHUNK-bit carry-select adder slice. Two ripple adders
// evaluate the slice for carry-in 0 and carry-in 1 in parallel; the real
// carry-in then only drives the final 2:1 selection.
//
// Ports:
//   a, b  in  [CHUNK-1:0]  operand slices
//   cin   in  1            carry into the slice
//   sum   out [CHUNK-1:0]  slice sum
//   cout  out 1            carry out of the slice
// -----------------------------------------------------------------------------
module z_csa_chunk
   import z_csa_pkg::*;
#(
   parameter int CHUNK = Z_CSA_CHUNK_DEF
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK-1:0] sum0_s;
   logic [CHUNK-1:0] sum1_s;
   logic [CHUNK:0]   c0_s;
   logic [CHUNK:0]   c1_s;

   // Two speculative ripple adders, one per possible carry-in.
   always_comb begin
      c0_s    = {(CHUNK+1){1'b0}};
      c1_s    = {(CHUNK+1){1'b0}};
      sum0_s  = {CHUNK{1'b0}};
      sum1_s  = {CHUNK{1'b0}};
      c0_s[0] = 1'b0;
      c1_s[0] = 1'b1;
      for (int i = 0; i < CHUNK; i++) begin
         sum0_s[i]  = a[i] ^ b[i] ^ c0_s[i];
         c0_s[i+1]  = (a[i] & b[i]) | (c0_s[i] & (a[i] ^ b[i]));
         sum1_s[i]  = a[i] ^ b[i] ^ c1_s[i];
         c1_s[i+1]  = (a[i] & b[i]) | (c1_s[i] & (a[i] ^ b[i]));
      end
   end

   // Late select by the actual carry-in.
   always_comb begin
      if (cin) begin
         sum  = sum1_s;
         cout = c1_s[CHUNK];
      end else begin
         sum  = sum0_s;
         cout = c0_s[CHUNK];
      end
   end

endmodule

// File: rtl/z_csa_seq_ctrl.sv
// -----------------------------------------------------------------------------
// z_csa_seq_ctrl
// Sequential WIDTH-bit adder: {c_out,sum} = a + b + c_in. Operands are captured
// on an in_valid/in_ready handshake, then one CHUNK-bit slice is added per
// cycle by a carry-select slice adder, with the slice carry registered between
// cycles. The result is presented with out_valid and held until out_ready.
//
// Optional feature (macro Z_CSA_OVF_EN): adds output ovf, the two's-complement
// overflow flag of the captured operands, valid with the result.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand request valid
//   in_ready   out  high only when idle
//   a, b       in   [WIDTH-1:0] operands
//   c_in       in   carry into bit 0
//   out_valid  out  result valid (DONE state)
//   out_ready  in   consumer accepts result
//   sum        out  [WIDTH-1:0] registered result
//   c_out      out  registered carry out of bit WIDTH-1
//   ovf        out  registered signed overflow (Z_CSA_OVF_EN only)
// -----------------------------------------------------------------------------
module z_csa_seq_ctrl
   import z_csa_pkg::*;
#(
   parameter int WIDTH = Z_CSA_WIDTH_DEF,
   parameter int CHUNK = Z_CSA_CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef Z_CSA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = z_csa_idx_w(NCHUNK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   z_csa_state_e state_r;
   z_csa_state_e state_nxt_s;

   // Operands and result are held as arrays of chunks so the active slice is
   // a plain index by the chunk counter.
   logic [NCHUNK-1:0][CHUNK-1:0] a_r;
   logic [NCHUNK-1:0][CHUNK-1:0] b_r;
   logic [NCHUNK-1:0][CHUNK-1:0] sum_r;
   logic                         carry_r;
   logic                         c_out_r;
   logic [IDX_W-1:0]             idx_r;

   logic [CHUNK-1:0] a_chunk_s;
   logic [CHUNK-1:0] b_chunk_s;
   logic [CHUNK-1:0] chunk_sum_s;
   logic             chunk_cout_s;
   logic             accept_s;
   logic             run_s;
   logic             last_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (idx_r == LAST_IDX) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State decode: handshake outputs and datapath enables.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept_s  = 1'b0;
      run_s     = 1'b0;
      last_s    = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready = 1'b1;
            accept_s = in_valid;
         end
         RUN: begin
            run_s  = 1'b1;
            last_s = (idx_r == LAST_IDX);
         end
         DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   assign a_chunk_s = a_r[idx_r];
   assign b_chunk_s = b_r[idx_r];

   z_csa_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a    (a_chunk_s),
      .b    (b_chunk_s),
      .cin  (carry_r),
      .sum  (chunk_sum_s),
      .cout (chunk_cout_s)
   );

   // Operand capture and per-chunk accumulation of sum and carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         c_out_r <= 1'b0;
         idx_r   <= {IDX_W{1'b0}};
      end else if (accept_s) begin
         a_r     <= a;
         b_r     <= b;
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= c_in;
         c_out_r <= 1'b0;
         idx_r   <= {IDX_W{1'b0}};
      end else if (run_s) begin
         sum_r[idx_r] <= chunk_sum_s;
         carry_r      <= chunk_cout_s;
         if (last_s) begin
            c_out_r <= chunk_cout_s;
            idx_r   <= {IDX_W{1'b0}};
         end else begin
            idx_r   <= idx_r + IDX_W'(1'b1);
         end
      end
   end

   assign sum   = sum_r;
   assign c_out = c_out_r;

`ifdef Z_CSA_OVF_EN
   logic ovf_r;

   // Signed overflow: equal operand signs but result sign differs. The last
   // slice result carries the final sum MSB, so it is taken straight from the
   // slice adder on the cycle it is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (accept_s) begin
         ovf_r <= 1'b0;
      end else if (last_s) begin
         ovf_r <= (a_r[NCHUNK-1][CHUNK-1] == b_r[NCHUNK-1][CHUNK-1]) &&
                  (chunk_sum_s[CHUNK-1] != a_r[NCHUNK-1][CHUNK-1]);
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_z_csa_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z_csa_seq_ctrl
// Self-checking bench for z_csa_seq_ctrl (default WIDTH=32, CHUNK=8).
// Directed cases plus 1000 randomized back-to-back requests checked against
// a transaction-level reference (a + b + c_in, fixed latency, valid/ready).
// Define Z_CSA_OVF_EN to also exercise the ovf output.
// -----------------------------------------------------------------------------
module tb_z_csa_seq_ctrl;

   localparam int W   = 32;
   localparam int CH  = 8;
   localparam int NCH = W / CH;
   localparam int NRND = 1000;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          c_out;
`ifdef Z_CSA_OVF_EN
   logic          ovf;
`endif

   int n_cmp;
   int n_err;

   z_csa_seq_ctrl #(
      .WIDTH (W),
      .CHUNK (CH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out)
`ifdef Z_CSA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned sum with carry out.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      return (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
   endfunction

   // Reference: signed overflow judged on the true integer value.
   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      longint s;
      s = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'hFFFF_FFFF;
         1:       v = 32'h0000_0000;
         2:       v = 32'h8000_0000;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // One directed request; holds out_ready low for 'hold' cycles once valid.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input int hold);
      logic [W:0] e;
      int lat;
      e = ref_sum(ta, tb_v, tc);
      @(negedge clk);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      a = ta; b = tb_v; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      // Operands may change freely after acceptance.
      in_valid = 1'b0; a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(NCH));
      chk({tag, "_result"}, 64'({c_out, sum}), 64'(e));
      chk({tag, "_busy"}, 64'(in_ready), 64'(0));
`ifdef Z_CSA_OVF_EN
      chk({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(ta, tb_v, tc)));
`endif
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
         chk({tag, "_hold_ready"}, 64'(in_ready), 64'(0));
         chk({tag, "_hold_result"}, 64'({c_out, sum}), 64'(e));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ret_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_ret_ready"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      logic         busy;
      int           cnt;
      int           n_acc;
      int           cyc;
      logic [W:0]   exp_r;
      logic         exp_ovf;

      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = 32'h0; b = 32'h0; c_in = 1'b0;
      exp_ovf = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_c_out", 64'(c_out), 64'(0));
`ifdef Z_CSA_OVF_EN
      chk("rst_ovf", 64'(ovf), 64'(0));
`endif
      rst_n = 1'b1;

      run_op("inc", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
      run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
      run_op("bp", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5);
`ifdef Z_CSA_OVF_EN
      run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
      run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
`endif

      // Reset during the second RUN cycle.
      @(negedge clk);
      a = 32'h0303_0303; b = 32'h0101_0101; c_in = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_sum", 64'(sum), 64'(32'h0000_0004));
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_sum", 64'(sum), 64'(0));
      chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
      chk("mid_rst_c_out", 64'(c_out), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_result", 64'(out_valid), 64'(0));
      end
      run_op("post_rst", 32'd5, 32'd7, 1'b0, 0);

      // Random back-to-back traffic against a transaction-level model.
      busy = 1'b0; cnt = 0; n_acc = 0; cyc = 0; exp_r = '0;
      while ((n_acc < NRND || busy) && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         chk("rnd_in_ready", 64'(in_ready), 64'(!busy));
         chk("rnd_out_valid", 64'(out_valid), 64'(busy && (cnt >= NCH)));
         if (busy && (cnt >= NCH)) begin
            chk("rnd_result", 64'({c_out, sum}), 64'(exp_r));
`ifdef Z_CSA_OVF_EN
            chk("rnd_ovf", 64'(ovf), 64'(exp_ovf));
`endif
         end
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (n_acc < NRND);
         a = rnd_op(); b = rnd_op(); c_in = 1'($urandom_range(0, 1));
         if (!busy) begin
            if (in_valid) begin
               busy    = 1'b1;
               cnt     = 0;
               exp_r   = ref_sum(a, b, c_in);
               exp_ovf = ref_ovf(a, b, c_in);
               n_acc++;
            end
         end else if ((cnt >= NCH) && out_ready) begin
            busy = 1'b0;
         end else begin
            cnt++;
         end
      end
      chk("rnd_accepted", 64'(n_acc), 64'(NRND));
      chk("rnd_drained", 64'(busy), 64'(0));
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/z_csa_seq_ctrl.md
Z_CSA_SEQ_CTRL -- requirements
Module: z_csa_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port c_in  input  1  carry into bit 0.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  registered result.
REQ-013 SHALL have port c_out  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, on in_valid&&in_ready in IDLE, capture a, b and c_in into internal registers, clear chunk index to 0, and enter RUN.
REQ-017 SHALL, each RUN cycle, add chunk k of A and B plus the registered carry with a carry-select chunk adder, write the chunk result to sum bits [k*CHUNK +: CHUNK], and register the chunk carry.
REQ-018 SHALL select the chunk result by registered carry: both carry-in=0 and carry-in=1 results are computed in parallel and muxed.
REQ-019 SHALL leave RUN for DONE after chunk WIDTH/CHUNK-1, so out_valid rises exactly WIDTH/CHUNK cycles after the accepting edge (4 cycles at defaults).
REQ-020 SHALL assert out_valid only in DONE, holding sum and c_out stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on out_valid&&out_ready, return to IDLE; a new request is accepted no earlier than the next cycle (no same-cycle accept).
REQ-022 SHALL ignore in_valid in RUN and DONE; operand inputs may change freely after acceptance.
REQ-023 SHALL compute {c_out,sum} = a + b + c_in modulo 2^(WIDTH+1), unsigned.
REQ-024 SHALL, when WIDTH==CHUNK, complete in one RUN cycle.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-RUN, immediately enter IDLE with in_ready=1, out_valid=0, sum=0, c_out=0, chunk index=0, carry register=0.
REQ-026 SHALL drop any in-flight operation on reset; no result is produced for it.

Configuration
REQ-027 SHALL, when macro Z_CSA_OVF_EN is defined, add output port ovf 1-bit, set in DONE to (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]) on the captured operands, reset to 0.
REQ-028 SHALL, when Z_CSA_OVF_EN is undefined, have no ovf port and no overflow logic.

Structure
REQ-029 SHALL place FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH/CHUNK constants in shared package z_csa_pkg.
REQ-030 SHALL instantiate one sub-module z_csa_chunk (CHUNK-wide carry-select adder: two ripple adders plus 2:1 muxes), purely combinational.
REQ-031 SHALL keep all registers inside z_csa_seq_ctrl.

Verification
REQ-032 Bench SHALL check: a=32'h0000_00FF, b=32'h0000_0001, c_in=0 -> after 4 cycles out_valid=1, sum=32'h0000_0100, c_out=0.
REQ-033 Bench SHALL check: a=32'hFFFF_FFFF, b=32'h0000_0000, c_in=1 -> sum=32'h0000_0000, c_out=1 (carry ripples through all chunks).
REQ-034 Bench SHALL check backpressure: out_ready=0 for 5 cycles after out_valid -> sum/c_out stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Bench SHALL check reset mid-RUN: rst_n low during cycle 2 of RUN -> same-cycle out_valid=0, sum=0, in_ready=1; next request a=5,b=7 -> sum=12.
REQ-036 Bench SHALL check (Z_CSA_OVF_EN) a=32'h7FFF_FFFF, b=32'h0000_0001 -> sum=32'h8000_0000, ovf=1, c_out=0; a=32'h8000_0000, b=32'h8000_0000 -> sum=0, c_out=1, ovf=1.
REQ-037 Bench SHALL run 1000 random back-to-back requests with random out_ready, comparing against a+b+c_in reference.
